// File: rtl/alsu_cmd_driver_if.sv
// Command and response handshake bundle between a requester and alsu_cmd_driver.
// master: command source / response sink. slave: the driver itself.
interface alsu_cmd_driver_if;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_opcode;
  logic signed [2:0] cmd_A;
  logic signed [2:0] cmd_B;
  logic              cmd_cin;
  logic              cmd_serial_in;
  logic              cmd_red_op_A;
  logic              cmd_red_op_B;
  logic              cmd_bypass_A;
  logic              cmd_bypass_B;
  logic              cmd_direction;
  logic [3:0]        cmd_tag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic signed [5:0] rsp_out;
  logic [15:0]       rsp_leds;
  logic [3:0]        rsp_tag;
  logic              rsp_invalid;

  modport master (
    output cmd_valid, cmd_opcode, cmd_A, cmd_B, cmd_cin, cmd_serial_in, cmd_red_op_A,
           cmd_red_op_B, cmd_bypass_A, cmd_bypass_B, cmd_direction, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_out, rsp_leds, rsp_tag, rsp_invalid
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_A, cmd_B, cmd_cin, cmd_serial_in, cmd_red_op_A,
           cmd_red_op_B, cmd_bypass_A, cmd_bypass_B, cmd_direction, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_out, rsp_leds, rsp_tag, rsp_invalid
  );
endinterface

// File: rtl/alsu_cmd_driver.sv
// Issues tagged commands to a 2-cycle-latency ALSU, samples its results into a
// FWFT response FIFO, and supports a software flush of in-flight operations.
module alsu_cmd_driver #(
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sw_rst,
  alsu_cmd_driver_if.slave    bus,
  output logic                alsu_rst,
  output logic [2:0]          alsu_opcode,
  output logic signed [2:0]   alsu_A,
  output logic signed [2:0]   alsu_B,
  output logic                alsu_cin,
  output logic                alsu_serial_in,
  output logic                alsu_red_op_A,
  output logic                alsu_red_op_B,
  output logic                alsu_bypass_A,
  output logic                alsu_bypass_B,
  output logic                alsu_direction,
  input  logic signed [5:0]   alsu_out,
  input  logic [15:0]         alsu_leds,
  output logic [15:0]         issued_cnt,
  output logic [15:0]         retired_cnt
);

  localparam int unsigned AW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  typedef struct packed {
    logic signed [5:0] out;
    logic [15:0]       leds;
    logic [3:0]        tag;
    logic              invalid;
  } rsp_t;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, FLUSH = 2'd2} state_t;

  state_t         state, state_next;
  logic           flush_cnt, flush_cnt_next;
  logic           sw_pulse;
  logic           iss_v, s1_v, s2_v;
  logic [3:0]     iss_tag, s1_tag, s2_tag;
  logic           iss_inv, s1_inv, s2_inv;
  rsp_t           mem [RSP_DEPTH];
  rsp_t           head;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic [1:0]     inflight;
  logic           credit_ok, xfer, push, pop, cmd_inv;

  // The issue register counts as in flight: its result is still owed a FIFO slot.
  assign inflight  = {1'b0, iss_v} + {1'b0, s1_v} + {1'b0, s2_v};
  assign credit_ok = (32'(count) + 32'(inflight)) < RSP_DEPTH;
  assign bus.cmd_ready = !rst && !sw_rst && (state != FLUSH) && credit_ok;
  assign xfer = bus.cmd_valid && bus.cmd_ready;

  assign cmd_inv = !bus.cmd_bypass_A && !bus.cmd_bypass_B &&
                   ((bus.cmd_opcode == 3'd6) || (bus.cmd_opcode == 3'd7) ||
                    ((bus.cmd_opcode > 3'd1) && (bus.cmd_red_op_A || bus.cmd_red_op_B)));

  assign bus.rsp_valid = !rst && (count != '0);
  assign pop  = bus.rsp_valid && bus.rsp_ready;
  assign push = s2_v && !sw_rst;

  assign alsu_rst = rst || sw_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_pulse       <= 1'b0;
      alsu_opcode    <= '0;
      alsu_A         <= '0;
      alsu_B         <= '0;
      alsu_cin       <= 1'b0;
      alsu_serial_in <= 1'b0;
      alsu_red_op_A  <= 1'b0;
      alsu_red_op_B  <= 1'b0;
      alsu_bypass_A  <= 1'b0;
      alsu_bypass_B  <= 1'b0;
      alsu_direction <= 1'b0;
    end else begin
      sw_pulse       <= sw_rst;
      alsu_opcode    <= xfer ? bus.cmd_opcode : 3'd0;
      alsu_A         <= xfer ? bus.cmd_A : 3'sd0;
      alsu_B         <= xfer ? bus.cmd_B : 3'sd0;
      alsu_cin       <= xfer && bus.cmd_cin;
      alsu_serial_in <= xfer && bus.cmd_serial_in;
      alsu_red_op_A  <= xfer && bus.cmd_red_op_A;
      alsu_red_op_B  <= xfer && bus.cmd_red_op_B;
      alsu_bypass_A  <= xfer && bus.cmd_bypass_A;
      alsu_bypass_B  <= xfer && bus.cmd_bypass_B;
      alsu_direction <= xfer && bus.cmd_direction;
    end
  end

  // Tag pipeline: issue -> s1 -> s2; s2 lines up with the ALSU result.
  always_ff @(posedge clk) begin
    if (rst || sw_rst) begin
      {iss_v, s1_v, s2_v}       <= '0;
      {iss_tag, s1_tag, s2_tag} <= '0;
      {iss_inv, s1_inv, s2_inv} <= '0;
    end else begin
      iss_v   <= xfer;
      iss_tag <= bus.cmd_tag;
      iss_inv <= cmd_inv;
      s1_v    <= iss_v;
      s1_tag  <= iss_tag;
      s1_inv  <= iss_inv;
      s2_v    <= s1_v;
      s2_tag  <= s1_tag;
      s2_inv  <= s1_inv;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{out: alsu_out, leds: alsu_leds, tag: s2_tag, invalid: s2_inv};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      issued_cnt  <= '0;
      retired_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (xfer) issued_cnt  <= issued_cnt + 16'd1;
      if (pop)  retired_cnt <= retired_cnt + 16'd1;
    end
  end

  assign head            = mem[rd_ptr];
  assign bus.rsp_out     = head.out;
  assign bus.rsp_leds    = head.leds;
  assign bus.rsp_tag     = head.tag;
  assign bus.rsp_invalid = head.invalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= 1'b0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    if (sw_rst) begin
      state_next     = FLUSH;
      flush_cnt_next = 1'b1;
    end else begin
      case (state)
        FLUSH: begin
          if (flush_cnt) flush_cnt_next = 1'b0;
          else           state_next     = IDLE;
        end
        default: state_next = (xfer || iss_v || s1_v) ? BUSY : IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alsu_cmd_driver.sv
// Directed bench for alsu_cmd_driver with a small 2-cycle ALSU stand-in; a second
// instance (RSP_DEPTH=8) streams at full rate to exercise counter wrap.
module tb_alsu_cmd_driver;
  logic clk = 1'b0;
  logic rst, sw_rst;
  always #5 clk = ~clk;

  alsu_cmd_driver_if bus ();
  alsu_cmd_driver_if bus8 ();

  logic              alsu_rst, alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
  logic              alsu_bypass_A, alsu_bypass_B, alsu_direction;
  logic [2:0]        alsu_opcode;
  logic signed [2:0] alsu_A, alsu_B;
  logic signed [5:0] alsu_out;
  logic [15:0]       alsu_leds, issued_cnt, retired_cnt;

  logic              a8_rst, a8_cin, a8_si, a8_ra, a8_rb, a8_ba, a8_bb, a8_dir;
  logic [2:0]        a8_op;
  logic signed [2:0] a8_A, a8_B;
  logic [15:0]       issued8, retired8;

  alsu_cmd_driver dut (
    .clk(clk), .rst(rst), .sw_rst(sw_rst), .bus(bus),
    .alsu_rst(alsu_rst), .alsu_opcode(alsu_opcode), .alsu_A(alsu_A), .alsu_B(alsu_B),
    .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in), .alsu_red_op_A(alsu_red_op_A),
    .alsu_red_op_B(alsu_red_op_B), .alsu_bypass_A(alsu_bypass_A),
    .alsu_bypass_B(alsu_bypass_B), .alsu_direction(alsu_direction),
    .alsu_out(alsu_out), .alsu_leds(alsu_leds),
    .issued_cnt(issued_cnt), .retired_cnt(retired_cnt)
  );

  alsu_cmd_driver #(.RSP_DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .sw_rst(1'b0), .bus(bus8),
    .alsu_rst(a8_rst), .alsu_opcode(a8_op), .alsu_A(a8_A), .alsu_B(a8_B),
    .alsu_cin(a8_cin), .alsu_serial_in(a8_si), .alsu_red_op_A(a8_ra),
    .alsu_red_op_B(a8_rb), .alsu_bypass_A(a8_ba), .alsu_bypass_B(a8_bb),
    .alsu_direction(a8_dir), .alsu_out(6'sd0), .alsu_leds(16'h0),
    .issued_cnt(issued8), .retired_cnt(retired8)
  );

  // ALSU stand-in: input register then output register (2-cycle latency).
  logic [2:0]        r_op;
  logic signed [2:0] r_A, r_B;
  logic              r_cin;
  always @(posedge clk) begin
    if (alsu_rst) begin
      r_op <= '0; r_A <= '0; r_B <= '0; r_cin <= 1'b0;
      alsu_out <= '0; alsu_leds <= '0;
    end else begin
      r_op <= alsu_opcode; r_A <= alsu_A; r_B <= alsu_B; r_cin <= alsu_cin;
      case (r_op)
        3'd2:       alsu_out <= 6'(r_A) + 6'(r_B) + 6'(r_cin);
        3'd6, 3'd7: begin alsu_out <= '0; alsu_leds <= ~alsu_leds; end
        default:    alsu_out <= {r_B, r_A};
      endcase
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                      input logic cin, input logic red_a, input logic byp_a,
                      input logic [3:0] tag);
    bus.cmd_opcode = op; bus.cmd_A = a; bus.cmd_B = b; bus.cmd_cin = cin;
    bus.cmd_red_op_A = red_a; bus.cmd_bypass_A = byp_a; bus.cmd_tag = tag;
    bus.cmd_valid = 1'b1;
    check("send_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!bus.rsp_valid && n < 20) begin tick(); n++; end
    check(tag, bus.rsp_valid, 1);
  endtask

  task automatic pop_one();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int n, sent, pops, cyc, seen;
    logic [15:0] iss8;
    rst = 1'b1; sw_rst = 1'b0;
    bus.cmd_valid = 0; bus.cmd_opcode = 0; bus.cmd_A = 0; bus.cmd_B = 0; bus.cmd_cin = 0;
    bus.cmd_serial_in = 0; bus.cmd_red_op_A = 0; bus.cmd_red_op_B = 0;
    bus.cmd_bypass_A = 0; bus.cmd_bypass_B = 0; bus.cmd_direction = 0; bus.cmd_tag = 0;
    bus.rsp_ready = 0;
    bus8.cmd_valid = 0; bus8.cmd_opcode = 0; bus8.cmd_A = 0; bus8.cmd_B = 0;
    bus8.cmd_cin = 0; bus8.cmd_serial_in = 0; bus8.cmd_red_op_A = 0;
    bus8.cmd_red_op_B = 0; bus8.cmd_bypass_A = 0; bus8.cmd_bypass_B = 0;
    bus8.cmd_direction = 0; bus8.cmd_tag = 0; bus8.rsp_ready = 1;
    repeat (3) tick();
    check("rst_alsu_rst", alsu_rst, 1);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_issued", issued_cnt, 0);
    check("rst_retired", retired_cnt, 0);
    check("rst_opcode", alsu_opcode, 0);
    rst = 1'b0;
    #1;
    check("post_rst_alsu_rst", alsu_rst, 0);
    check("post_rst_cmd_ready", bus.cmd_ready, 1);

    // ADD 3 + 2 + 1
    send(3'd2, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0, 4'd5);
    check("issue_opcode", alsu_opcode, 2);
    check("issue_A", {29'b0, alsu_A}, 3);
    check("issue_B", {29'b0, alsu_B}, 2);
    check("issue_cin", alsu_cin, 1);
    tick();
    check("nop_opcode", alsu_opcode, 0);
    check("nop_cin", alsu_cin, 0);
    check("add_valid_t1", bus.rsp_valid, 0);
    tick();
    check("add_valid_t2", bus.rsp_valid, 0);
    tick();
    check("add_valid_t3", bus.rsp_valid, 1);
    check("add_out", {26'b0, bus.rsp_out}, 6);
    check("add_tag", bus.rsp_tag, 5);
    check("add_invalid", bus.rsp_invalid, 0);
    check("add_leds", bus.rsp_leds, 16'h0000);
    pop_one();
    check("add_popped", bus.rsp_valid, 0);
    check("add_retired", retired_cnt, 1);
    check("add_issued", issued_cnt, 1);

    // Invalid opcode 6, reduction with opcode 3, and bypass masking invalid
    send(3'd6, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 4'd9);
    wait_rsp("inv_rsp_valid");
    check("inv_out", {26'b0, bus.rsp_out}, 0);
    check("inv_invalid", bus.rsp_invalid, 1);
    check("inv_leds", bus.rsp_leds, 16'hFFFF);
    check("inv_tag", bus.rsp_tag, 9);
    pop_one();
    send(3'd3, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 4'd10);
    wait_rsp("red_rsp_valid");
    check("red_invalid", bus.rsp_invalid, 1);
    check("red_tag", bus.rsp_tag, 10);
    check("red_out", {26'b0, bus.rsp_out}, 17);
    pop_one();
    send(3'd3, 3'd1, 3'd2, 1'b0, 1'b1, 1'b1, 4'd11);
    wait_rsp("byp_rsp_valid");
    check("byp_invalid", bus.rsp_invalid, 0);
    check("byp_tag", bus.rsp_tag, 11);
    pop_one();
    check("mid_issued", issued_cnt, 4);
    check("mid_retired", retired_cnt, 4);

    // Back-pressure: only RSP_DEPTH transfers while rsp_ready is low
    bus.cmd_opcode = 0; bus.cmd_A = 0; bus.cmd_B = 0; bus.cmd_red_op_A = 0;
    bus.cmd_bypass_A = 0;
    n = 0;
    bus.cmd_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.cmd_tag = n[3:0];
      if (bus.cmd_ready) n++;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("bp_transfers", n, 4);
    check("bp_cmd_ready", bus.cmd_ready, 0);
    check("bp_rsp_valid", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_tag", bus.rsp_tag, i);
      tick();
      if (i == 0) check("bp_ready_back", bus.cmd_ready, 1);
    end
    bus.rsp_ready = 1'b0;
    check("bp_empty", bus.rsp_valid, 0);
    check("bp_issued", issued_cnt, 8);
    check("bp_retired", retired_cnt, 8);

    // Flush: FIFO entry 12 survives, tags 1/2 are dropped, tag 3 is refused
    send(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd12);
    repeat (4) tick();
    check("fl_pre_valid", bus.rsp_valid, 1);
    send(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd1);
    send(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd2);
    sw_rst = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_tag = 4'd3;
    #1;
    check("fl_block", bus.cmd_ready, 0);
    tick();
    sw_rst = 1'b0;
    bus.cmd_valid = 1'b0;
    check("fl_alsu_rst_on", alsu_rst, 1);
    tick();
    check("fl_alsu_rst_off", alsu_rst, 0);
    check("fl_ready_c2", bus.cmd_ready, 0);
    tick();
    check("fl_ready_idle", bus.cmd_ready, 1);
    repeat (5) tick();
    check("fl_keep_valid", bus.rsp_valid, 1);
    check("fl_keep_tag", bus.rsp_tag, 12);
    pop_one();
    seen = 0;
    repeat (5) begin
      if (bus.rsp_valid) seen++;
      tick();
    end
    check("fl_no_rsp", seen, 0);
    check("fl_issued", issued_cnt, 11);
    check("fl_retired", retired_cnt, 9);

    // Full FIFO, then push and pop together while streaming 20 tags
    sent = 0; pops = 0;
    bus.cmd_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.cmd_tag = sent[3:0];
      if (bus.cmd_ready) sent++;
      tick();
    end
    check("fs_full_ready", bus.cmd_ready, 0);
    check("fs_full_sent", sent, 4);
    bus.rsp_ready = 1'b1;
    cyc = 0;
    while ((sent < 20 || pops < 20) && cyc < 200) begin
      bus.cmd_valid = (sent < 20);
      bus.cmd_tag = sent[3:0];
      if (bus.rsp_valid) begin
        check("fs_tag", bus.rsp_tag, pops[3:0]);
        pops++;
      end
      if (bus.cmd_valid && bus.cmd_ready) sent++;
      tick();
      cyc++;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    check("fs_pops", pops, 20);
    check("fs_sent", sent, 20);
    check("fs_issued", issued_cnt, 31);
    check("fs_retired", retired_cnt, 29);

    // Counter wrap on the deeper instance
    iss8 = 16'h0;
    cyc = 0;
    while (iss8 != 16'hFFFF && cyc < 70000) begin
      bus8.cmd_valid = 1'b1;
      if (bus8.cmd_ready) iss8++;
      tick();
      cyc++;
    end
    bus8.cmd_valid = 1'b0;
    tick();
    check("wrap_pre", issued8, 16'hFFFF);
    bus8.cmd_valid = 1'b1;
    n = 0;
    while (!bus8.cmd_ready && n < 10) begin tick(); n++; end
    check("wrap_ready", bus8.cmd_ready, 1);
    tick();
    bus8.cmd_valid = 1'b0;
    check("wrap_issued", issued8, 16'h0000);
    repeat (10) tick();
    check("wrap_retired", retired8, 16'h0000);
    check("wrap_drained", bus8.rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
